// File: rtl/dehaze_recover.sv
// dehaze_recover: final dark-channel-prior stage, J = A + (I - A)*255/t per channel, clamped to 0..255.
// Five register stages with no stall; the syncs ride a matching delay line.
module dehaze_recover #(
  parameter logic [7:0] T_MIN   = 8'd26,
  parameter logic [7:0] A_MIN   = 8'd128,
  parameter logic [7:0] A_RESET = 8'd255,
  parameter int         LATENCY = 5
) (
  input  logic        pixelclk,
  input  logic        reset_n,
  input  logic [23:0] i_rgb,
  input  logic [7:0]  i_transmittance,
  input  logic [7:0]  i_dark_max,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic        i_bypass,
  output logic [23:0] o_rgb,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [7:0]  o_a_frame
);
  logic               vs_prev;
  logic [7:0]         a_frame;
  logic [LATENCY-1:0] hs_d, vs_d, de_d;
  logic [11:0]        rom [256];
  logic [23:0]        rgb1, rgb2, rgb3, rgb4;
  logic               byp1, byp2, byp3, byp4;
  logic [7:0]         tc1, a2, a3;
  logic [11:0]        recip2;
  logic signed [8:0]  diff2 [3];
  logic signed [20:0] prod3 [3];
  logic signed [12:0] sum4 [3];
  // Entries below T_MIN are never addressed; they mirror T_MIN to keep the table total.
  genvar g;
  generate
    for (g = 0; g < 256; g++) begin : g_rom
      assign rom[g] = 12'(65280 / ((g < int'(T_MIN)) ? int'(T_MIN) : g));
    end
  endgenerate
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev <= 1'b0;
      a_frame <= A_RESET;
    end else begin
      vs_prev <= i_vsync;
      if (i_vsync && !vs_prev) a_frame <= (i_dark_max > A_MIN) ? i_dark_max : A_MIN;
    end
  end
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      hs_d   <= '0;
      vs_d   <= '0;
      de_d   <= '0;
      rgb1   <= '0;
      rgb2   <= '0;
      rgb3   <= '0;
      rgb4   <= '0;
      byp1   <= 1'b0;
      byp2   <= 1'b0;
      byp3   <= 1'b0;
      byp4   <= 1'b0;
      tc1    <= '0;
      a2     <= '0;
      a3     <= '0;
      recip2 <= '0;
      o_rgb  <= '0;
      for (int c = 0; c < 3; c++) begin
        diff2[c] <= '0;
        prod3[c] <= '0;
        sum4[c]  <= '0;
      end
    end else begin
      hs_d   <= {hs_d[LATENCY-2:0], i_hsync};
      vs_d   <= {vs_d[LATENCY-2:0], i_vsync};
      de_d   <= {de_d[LATENCY-2:0], i_de};
      rgb1   <= i_rgb;
      byp1   <= i_bypass;
      tc1    <= (i_transmittance > T_MIN) ? i_transmittance : T_MIN;
      rgb2   <= rgb1;
      byp2   <= byp1;
      a2     <= a_frame;
      recip2 <= rom[tc1];
      rgb3   <= rgb2;
      byp3   <= byp2;
      a3     <= a2;
      rgb4   <= rgb3;
      byp4   <= byp3;
      for (int c = 0; c < 3; c++) begin
        diff2[c] <= $signed({1'b0, rgb1[8*c +: 8]}) - $signed({1'b0, a_frame});
        prod3[c] <= 21'(diff2[c]) * 21'($signed({1'b0, recip2}));
        // Kept wide enough for the full -2501..+1245 offset range so the clamp never sees a wrapped value.
        sum4[c]  <= $signed({5'd0, a3}) + 13'(prod3[c] >>> 8);
        o_rgb[8*c +: 8] <= !de_d[LATENCY-2] ? 8'd0 :
                           byp4 ? rgb4[8*c +: 8] :
                           sum4[c][12] ? 8'd0 :
                           (sum4[c] > 13'sd255) ? 8'd255 : sum4[c][7:0];
      end
    end
  end
  assign o_hsync   = hs_d[LATENCY-1];
  assign o_vsync   = vs_d[LATENCY-1];
  assign o_de      = de_d[LATENCY-1];
  assign o_a_frame = a_frame;
endmodule

// File: tb/tb_dehaze_recover.sv
// tb_dehaze_recover: directed vector table plus random frames, checked against an arithmetic reference of the recovery formula.
module tb_dehaze_recover;
  logic        pixelclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] i_rgb = '0;
  logic [7:0]  i_transmittance = '0;
  logic [7:0]  i_dark_max = '0;
  logic        i_hsync = 1'b0;
  logic        i_vsync = 1'b0;
  logic        i_de = 1'b0;
  logic        i_bypass = 1'b0;
  logic [23:0] o_rgb;
  logic        o_hsync, o_vsync, o_de;
  logic [7:0]  o_a_frame;

  dehaze_recover dut (
    .pixelclk(pixelclk), .reset_n(reset_n), .i_rgb(i_rgb), .i_transmittance(i_transmittance),
    .i_dark_max(i_dark_max), .i_hsync(i_hsync), .i_vsync(i_vsync), .i_de(i_de), .i_bypass(i_bypass),
    .o_rgb(o_rgb), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de), .o_a_frame(o_a_frame)
  );

  always #5 pixelclk = ~pixelclk;

  typedef struct {
    logic        de, hs, vs;
    logic [23:0] rgb;
  } exp_t;

  typedef struct {
    logic [7:0]  dark, t;
    logic [23:0] rgb;
    logic        byp;
    logic [23:0] exp_rgb;
    logic [7:0]  exp_a;
  } vec_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  int   a_model = 255;
  logic vs_prev_m = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // J = A + floor((I - A) * floor(65280 / max(t, 26)) / 256), clamped to a byte
  function automatic logic [23:0] recover(input int a, input int t, input logic [23:0] rgb, input logic byp);
    int tc, rc, p, d, j;
    logic [23:0] r;
    if (byp) return rgb;
    tc = (t < 26) ? 26 : t;
    rc = 65280 / tc;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      p = (int'(rgb[8*c +: 8]) - a) * rc;
      d = (p >= 0) ? p / 256 : -((-p + 255) / 256);
      j = a + d;
      j = (j < 0) ? 0 : (j > 255) ? 255 : j;
      r[8*c +: 8] = 8'(j);
    end
    return r;
  endfunction

  task automatic reset_model;
    exp_t z;
    z = '{de: 1'b0, hs: 1'b0, vs: 1'b0, rgb: 24'd0};
    q.delete();
    repeat (4) q.push_back(z);
    a_model   = 255;
    vs_prev_m = 1'b0;
  endtask

  task automatic tick;
    exp_t e;
    @(posedge pixelclk);
    if (i_vsync && !vs_prev_m) a_model = (i_dark_max < 8'd128) ? 128 : int'(i_dark_max);
    vs_prev_m = i_vsync;
    e.de  = i_de;
    e.hs  = i_hsync;
    e.vs  = i_vsync;
    e.rgb = i_de ? recover(a_model, int'(i_transmittance), i_rgb, i_bypass) : 24'd0;
    q.push_back(e);
    #1;
    if (q.size() == 5) begin
      e = q.pop_front();
      check("o_rgb", o_rgb, e.rgb);
      check("o_de", o_de, e.de);
      check("o_hsync", o_hsync, e.hs);
      check("o_vsync", o_vsync, e.vs);
    end
    check("o_a_frame", o_a_frame, a_model);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{dark: 8'd200, t: 8'd255, rgb: {8'd180, 8'd200, 8'd10},  byp: 1'b0, exp_rgb: {8'd180, 8'd200, 8'd10},  exp_a: 8'd200};
    vecs[1] = '{dark: 8'd200, t: 8'd128, rgb: {8'd100, 8'd100, 8'd100}, byp: 1'b0, exp_rgb: 24'd0,                      exp_a: 8'd200};
    vecs[2] = '{dark: 8'd200, t: 8'd10,  rgb: {8'd201, 8'd210, 8'd199}, byp: 1'b0, exp_rgb: {8'd209, 8'd255, 8'd190}, exp_a: 8'd200};
    vecs[3] = '{dark: 8'd90,  t: 8'd255, rgb: {8'd50, 8'd60, 8'd70},    byp: 1'b0, exp_rgb: {8'd50, 8'd60, 8'd70},    exp_a: 8'd128};
    vecs[4] = '{dark: 8'd200, t: 8'd60,  rgb: {8'd200, 8'd200, 8'd200}, byp: 1'b0, exp_rgb: {8'd200, 8'd200, 8'd200}, exp_a: 8'd200};
    vecs[5] = '{dark: 8'd150, t: 8'd30,  rgb: {8'd1, 8'd2, 8'd3},       byp: 1'b1, exp_rgb: {8'd1, 8'd2, 8'd3},       exp_a: 8'd150};

    reset_model();
    #12;
    check("reset_rgb", o_rgb, 24'd0);
    check("reset_de", o_de, 1'b0);
    check("reset_a_frame", o_a_frame, 8'd255);
    reset_n = 1'b1;
    repeat (2) tick();

    foreach (vecs[k]) begin
      i_vsync = 1'b0;
      i_de    = 1'b0;
      tick();
      i_vsync         = 1'b1;
      i_dark_max      = vecs[k].dark;
      i_transmittance = vecs[k].t;
      i_rgb           = vecs[k].rgb;
      i_bypass        = vecs[k].byp;
      i_de            = 1'b1;
      tick();
      i_de       = 1'b0;
      i_rgb      = '0;
      i_dark_max = 8'd17;
      repeat (4) tick();
      check($sformatf("vec%0d_rgb", k), o_rgb, vecs[k].exp_rgb);
      check($sformatf("vec%0d_de", k), o_de, 1'b1);
      check($sformatf("vec%0d_a", k), o_a_frame, vecs[k].exp_a);
    end

    for (int f = 0; f < 4; f++) begin
      i_vsync    = 1'b1;
      i_de       = 1'b0;
      i_dark_max = 8'($urandom_range(60, 255));
      tick();
      tick();
      i_vsync = 1'b0;
      for (int p = 0; p < 60; p++) begin
        i_de            = ($urandom_range(0, 3) != 0);
        i_hsync         = (p % 20) < 2;
        i_rgb           = 24'($urandom);
        i_transmittance = 8'($urandom);
        i_dark_max      = 8'($urandom);
        i_bypass        = p[0];
        tick();
        if (f == 2 && p == 30) begin
          #2 reset_n = 1'b0;
          #1;
          check("midreset_rgb", o_rgb, 24'd0);
          check("midreset_de", o_de, 1'b0);
          check("midreset_hsync", o_hsync, 1'b0);
          check("midreset_vsync", o_vsync, 1'b0);
          check("midreset_a_frame", o_a_frame, 8'd255);
          repeat (2) @(posedge pixelclk);
          #2 reset_n = 1'b1;
          reset_model();
        end
      end
    end
    i_de = 1'b0;
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
